seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/div_sub_stage.sv | 23 ++
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when it does not borrow.
module div_sub_stage #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] p,
   input  logic             din,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] p_next,
   output logic             q_bit
);

   logic [WIDTH:0]   trial;
   logic [WIDTH+1:0] diff;

   // The extra top bit of diff is the borrow of the WIDTH+1-bit subtraction.
   assign trial  = {p, din};
   assign diff   = {1'b0, trial} - {2'b00, divisor};
   assign q_bit  = ~diff[WIDTH+1];
   // Either choice is below the divisor here, so it always fits in WIDTH bits.
   assign p_next = WIDTH'(q_bit ? diff[WIDTH:0] : trial);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per cycle,
// MSB first, with a one-cycle done pulse and divide-by-zero flag.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] p_q, q_q, dvs_q, p_next;
   logic             q_bit, dbz_q, accept;

   assign accept = ready & start;

   // q_q holds the unconsumed dividend bits at the top and collects quotient
   // bits at the bottom, so after WIDTH shifts it holds only the quotient.
   div_sub_stage #(
      .WIDTH(WIDTH)
   ) u_stage (
      .p      (p_q),
      .din    (q_q[WIDTH-1]),
      .divisor(dvs_q),
      .p_next (p_next),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = (divisor == '0) ? StDone : StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cnt_q == CNT_LAST) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (state_q)
         StIdle:  ready = 1'b1;
         StRun:   busy  = 1'b1;
         StDone: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         p_q   <= '0;
         q_q   <= '0;
         dvs_q <= '0;
         dbz_q <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
         dvs_q <= divisor;
         if (divisor == '0) begin
            q_q   <= '1;
            p_q   <= dividend;
            dbz_q <= 1'b1;
         end else begin
            q_q   <= dividend;
            p_q   <= '0;
            dbz_q <= 1'b0;
         end
      end else if (state_q == StRun) begin
         q_q <= {q_q[WIDTH-2:0], q_bit};
         p_q <= p_next;
         if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign quotient    = q_q;
   assign remainder   = p_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at the default 16-bit width.
module tb_seq_divider;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;
   int lat;

   seq_divider #(
      .WIDTH(16)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one cycle, wait (bounded) for done, check results and the
   // cycle after done.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                        input logic edz);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      lat   = 1;
      start = 1'b0;
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_dbz"}, div_by_zero, edz);
      check({tag, "_ready_at_done"}, ready, 1'b1);
      step();
      check({tag, "_done_one_cycle"}, done, 1'b0);
      check({tag, "_quotient_stable"}, quotient, eq);
      check({tag, "_remainder_stable"}, remainder, er);
      check({tag, "_idle_ready"}, ready, 1'b1);
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #2;
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quotient", quotient, 16'h0);
      check("rst_remainder", remainder, 16'h0);
      check("rst_dbz", div_by_zero, 1'b0);
      step();
      step();
      reset_n = 1'b1;
      step();

      do_op("d100_7", 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0);
      do_op("ffff_1", 16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0);
      do_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 17, 16'd1, 16'd0, 1'b0);
      do_op("d5_0", 16'd5, 16'd0, 1, 16'hFFFF, 16'd5, 1'b1);

      // 3/10 with an ignored start pulse carrying 50/5 during the run.
      dividend = 16'd3;
      divisor  = 16'd10;
      start    = 1'b1;
      step();
      lat   = 1;
      start = 1'b0;
      check("small_busy", busy, 1'b1);
      check("small_not_ready", ready, 1'b0);
      check("small_dbz_cleared", div_by_zero, 1'b0);
      while (!done && lat < 40) begin
         if (lat == 8) begin
            start    = 1'b1;
            dividend = 16'd50;
            divisor  = 16'd5;
         end else begin
            start = 1'b0;
         end
         step();
         lat++;
      end
      start = 1'b0;
      check("small_latency", lat, 17);
      check("small_quotient", quotient, 16'd0);
      check("small_remainder", remainder, 16'd3);
      step();
      check("small_done_one_cycle", done, 1'b0);

      // Reset in the middle of 1000/3.
      dividend = 16'd1000;
      divisor  = 16'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("abort_busy_before", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("abort_ready", ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_quotient", quotient, 16'h0);
      check("abort_remainder", remainder, 16'h0);
      check("abort_dbz", div_by_zero, 1'b0);
      lat = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) lat++;
      end
      check("abort_no_done", lat, 0);
      reset_n = 1'b1;
      step();
      do_op("d1000_3", 16'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0);

      // Back-to-back: start held through the run and the DONE cycle.
      dividend = 16'd200;
      divisor  = 16'd9;
      start    = 1'b1;
      step();
      lat = 1;
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      check("b2b_first_latency", lat, 17);
      check("b2b_first_quotient", quotient, 16'd22);
      check("b2b_first_remainder", remainder, 16'd2);
      dividend = 16'd77;
      divisor  = 16'd7;
      step();
      lat = 1;
      start = 1'b0;
      check("b2b_second_busy", busy, 1'b1);
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      check("b2b_second_latency", lat, 17);
      check("b2b_second_quotient", quotient, 16'd11);
      check("b2b_second_remainder", remainder, 16'd0);
      step();
      check("b2b_second_done_one_cycle", done, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
